// File: rtl/mem_stage_206_pkg.sv
// Shared definitions for the MIPS memory-access stage: load-type encodings
// and default data-memory geometry.
package mem_stage_206_pkg;

    localparam int DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        LB_WORD     = 2'b00,
        LB_SIGNED   = 2'b01,
        LB_UNSIGNED = 2'b10,
        LB_RSVD     = 2'b11
    } load_type_e;

    // One-hot byte-enable for a single byte lane (little-endian).
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_stage_206_if.sv
// Ex/Mem inputs and Mem/Wr outputs of the memory stage, bundled as one bus.
// The Ex/Mem side is the master; the memory stage is the slave.
interface mem_stage_206_if;

    logic        flush_Mem;
    logic [31:0] ALU_ans_Mem;
    logic [31:0] busB_Mem;
    logic [31:0] B_Addr_Mem;
    logic [31:0] PC_Addr_Mem;
    logic [4:0]  Reg_Target_Mem;
    logic        ZF_Mem;
    logic        OF_Mem;
    logic        Branch_Mem;
    logic        MemToReg_Mem;
    logic        RegWr_Mem;
    logic        MemWr_Mem;
    logic        Jal_Mem;
    logic        WrByte_Mem;
    logic [1:0]  LoadByte_Mem;

    logic        PC_Src_Mem;
    logic [31:0] B_Addr_out_Mem;
    logic [31:0] busW_Wr;
    logic [4:0]  Rw_Wr;
    logic        RegWr_Wr;
    logic        OverFlow_Wr;
    logic        Jal_Wr;

    modport master (
        output flush_Mem, ALU_ans_Mem, busB_Mem, B_Addr_Mem, PC_Addr_Mem,
               Reg_Target_Mem, ZF_Mem, OF_Mem, Branch_Mem, MemToReg_Mem,
               RegWr_Mem, MemWr_Mem, Jal_Mem, WrByte_Mem, LoadByte_Mem,
        input  PC_Src_Mem, B_Addr_out_Mem, busW_Wr, Rw_Wr, RegWr_Wr,
               OverFlow_Wr, Jal_Wr
    );

    modport slave (
        input  flush_Mem, ALU_ans_Mem, busB_Mem, B_Addr_Mem, PC_Addr_Mem,
               Reg_Target_Mem, ZF_Mem, OF_Mem, Branch_Mem, MemToReg_Mem,
               RegWr_Mem, MemWr_Mem, Jal_Mem, WrByte_Mem, LoadByte_Mem,
        output PC_Src_Mem, B_Addr_out_Mem, busW_Wr, Rw_Wr, RegWr_Wr,
               OverFlow_Wr, Jal_Wr
    );

endinterface

// File: rtl/mem_stage_206_data_mem.sv
// Word-organised data memory with per-byte write enables and an
// asynchronous (combinational) read port. Contents are never reset.
module data_mem_206
    import mem_stage_206_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_206.sv
// MIPS memory-access stage: data memory access, load extension, branch
// resolution and the Mem/Wr pipeline register feeding write-back.
module mem_stage_206
    import mem_stage_206_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_stage_206_if.slave   bus
);

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              store_en;
    logic [3:0]        store_be;
    logic [31:0]       store_data;
    logic [31:0]       rdata;
    logic [31:0]       load_data;

    logic [31:0] busW_d, busW_q;
    logic [4:0]  Rw_d, Rw_q;
    logic        RegWr_d, RegWr_q;
    logic        OverFlow_d, OverFlow_q;
    logic        Jal_d, Jal_q;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  sel,
                                                input logic [1:0]  ld);
        logic [7:0] b;
        b = word[8*sel +: 8];
        case (load_type_e'(ld))
            LB_SIGNED:   return {{24{b[7]}}, b};
            LB_UNSIGNED: return {24'h0, b};
            default:     return word;
        endcase
    endfunction

    // Upper address bits are dropped, so addresses alias modulo DEPTH*4.
    assign word_idx   = bus.ALU_ans_Mem[ADDR_W+1:2];
    assign lane       = bus.ALU_ans_Mem[1:0];
    assign store_en   = bus.MemWr_Mem & ~bus.flush_Mem & ~rst;
    assign store_be   = bus.WrByte_Mem ? lane_mask(lane) : 4'hF;
    assign store_data = bus.WrByte_Mem ? {4{bus.busB_Mem[7:0]}} : bus.busB_Mem;

    data_mem_206 #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk_i   (clk),
        .we_i    (store_en),
        .be_i    (store_be),
        .addr_i  (word_idx),
        .wdata_i (store_data),
        .rdata_o (rdata)
    );

    assign load_data = extend_load(rdata, lane, bus.LoadByte_Mem);

    assign bus.PC_Src_Mem     = bus.Branch_Mem & bus.ZF_Mem & ~bus.flush_Mem;
    assign bus.B_Addr_out_Mem = bus.B_Addr_Mem;

    // A flushed instruction is captured as an all-zero bubble.
    always_comb begin
        busW_d     = 32'h0;
        Rw_d       = 5'h0;
        RegWr_d    = 1'b0;
        OverFlow_d = 1'b0;
        Jal_d      = 1'b0;
        if (!bus.flush_Mem) begin
            if (bus.Jal_Mem)           busW_d = bus.PC_Addr_Mem;
            else if (bus.MemToReg_Mem) busW_d = load_data;
            else                       busW_d = bus.ALU_ans_Mem;
            Rw_d       = bus.Reg_Target_Mem;
            RegWr_d    = bus.RegWr_Mem;
            OverFlow_d = bus.OF_Mem;
            Jal_d      = bus.Jal_Mem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busW_q     <= 32'h0;
            Rw_q       <= 5'h0;
            RegWr_q    <= 1'b0;
            OverFlow_q <= 1'b0;
            Jal_q      <= 1'b0;
        end else begin
            busW_q     <= busW_d;
            Rw_q       <= Rw_d;
            RegWr_q    <= RegWr_d;
            OverFlow_q <= OverFlow_d;
            Jal_q      <= Jal_d;
        end
    end

    assign bus.busW_Wr     = busW_q;
    assign bus.Rw_Wr       = Rw_q;
    assign bus.RegWr_Wr    = RegWr_q;
    assign bus.OverFlow_Wr = OverFlow_q;
    assign bus.Jal_Wr      = Jal_q;

endmodule

// File: tb/tb_mem_stage_206.sv
// Self-checking bench for mem_stage_206: directed scenarios plus randomized
// traffic checked against a byte-addressed reference memory.
module tb_mem_stage_206;

    localparam int DEPTH = 1024;
    localparam int BYTES = DEPTH * 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_stage_206_if bus ();

    mem_stage_206 #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [31:0] alu, busb, baddr, pc;
        logic [4:0]  rt;
        logic        zf, of, br, m2r, rw, mw, jal, wb;
        logic [1:0]  lb;
    } txn_t;

    logic [7:0] mem_m [BYTES];

    function automatic txn_t nop();
        txn_t t;
        t.flush = 0; t.alu = 0; t.busb = 0; t.baddr = 0; t.pc = 0; t.rt = 0;
        t.zf = 0; t.of = 0; t.br = 0; t.m2r = 0; t.rw = 0; t.mw = 0;
        t.jal = 0; t.wb = 0; t.lb = 0;
        return t;
    endfunction

    function automatic txn_t sw_t(input logic [31:0] a, input logic [31:0] d);
        txn_t t = nop();
        t.alu = a; t.busb = d; t.mw = 1;
        return t;
    endfunction

    function automatic txn_t ld_t(input logic [31:0] a, input logic [1:0] lb, input logic [4:0] rt);
        txn_t t = nop();
        t.alu = a; t.lb = lb; t.m2r = 1; t.rw = 1; t.rt = rt;
        return t;
    endfunction

    function automatic logic [31:0] m_load(input txn_t t);
        int unsigned ba, wa;
        int v;
        ba = t.alu % BYTES;
        wa = ba - (ba % 4);
        if (t.lb == 2'd1 || t.lb == 2'd2) begin
            v = int'(mem_m[ba]);
            if (t.lb == 2'd1 && v >= 128) v = v - 256;
            return 32'(v);
        end
        return {mem_m[wa+3], mem_m[wa+2], mem_m[wa+1], mem_m[wa]};
    endfunction

    function automatic logic [39:0] m_wr(input txn_t t);
        logic [31:0] w;
        if (t.flush) return 40'h0;
        if (t.jal)      w = t.pc;
        else if (t.m2r) w = m_load(t);
        else            w = t.alu;
        return {w, t.rt, t.rw, t.of, t.jal};
    endfunction

    task automatic m_store(input txn_t t);
        int unsigned ba, wa;
        if (!t.mw || t.flush) return;
        ba = t.alu % BYTES;
        wa = ba - (ba % 4);
        if (t.wb) mem_m[ba] = t.busb[7:0];
        else for (int k = 0; k < 4; k++) mem_m[wa+k] = t.busb[8*k +: 8];
    endtask

    task automatic apply(input txn_t t);
        bus.flush_Mem = t.flush;   bus.ALU_ans_Mem = t.alu;  bus.busB_Mem = t.busb;
        bus.B_Addr_Mem = t.baddr;  bus.PC_Addr_Mem = t.pc;   bus.Reg_Target_Mem = t.rt;
        bus.ZF_Mem = t.zf;         bus.OF_Mem = t.of;        bus.Branch_Mem = t.br;
        bus.MemToReg_Mem = t.m2r;  bus.RegWr_Mem = t.rw;     bus.MemWr_Mem = t.mw;
        bus.Jal_Mem = t.jal;       bus.WrByte_Mem = t.wb;    bus.LoadByte_Mem = t.lb;
    endtask

    // Drive one instruction through an edge; exp is the Wr-side outcome.
    task automatic cycle(input txn_t t, output logic [39:0] exp);
        apply(t);
        exp = rst ? 40'h0 : m_wr(t);
        @(posedge clk);
        #1;
        if (!rst) m_store(t);
    endtask

    function automatic logic [39:0] got();
        return {bus.busW_Wr, bus.Rw_Wr, bus.RegWr_Wr, bus.OverFlow_Wr, bus.Jal_Wr};
    endfunction

    task automatic init_mem();
        logic [39:0] e;
        for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h0;
        for (int i = 0; i < DEPTH; i++) cycle(sw_t(32'(i * 4), 32'h0), e);
    endtask

    task automatic test_reset();
        txn_t t;
        logic [39:0] e;
        rst = 1'b1;
        apply(nop());
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got() !== 40'h0) begin
            errors++; $display("FAIL reset_initial got %h want %h", got(), 40'h0);
        end
        rst = 1'b0;
        init_mem();
        t = nop(); t.alu = 32'h1234_5678; t.rw = 1; t.rt = 5'd5; t.of = 1;
        cycle(t, e);
        checks++;
        if (got() !== e) begin
            errors++; $display("FAIL reset_pre_alu got %h want %h", got(), e);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (got() !== 40'h0) begin
            errors++; $display("FAIL reset_async got %h want %h", got(), 40'h0);
        end
        cycle(sw_t(32'h40, 32'hDEAD_BEEF), e);
        cycle(sw_t(32'h40, 32'hDEAD_BEEF), e);
        rst = 1'b0;
        cycle(ld_t(32'h40, 2'b00, 5'd7), e);
        checks++;
        if (got() !== e || bus.busW_Wr !== 32'h0) begin
            errors++; $display("FAIL reset_no_store got %h want %h", got(), e);
        end
    endtask

    task automatic test_sw_lw();
        logic [39:0] e;
        txn_t t;
        cycle(sw_t(32'h10, 32'h8000_00F1), e);
        checks++;
        if (got() !== e) begin
            errors++; $display("FAIL sw_wr got %h want %h", got(), e);
        end
        cycle(ld_t(32'h10, 2'b00, 5'd3), e);
        checks++;
        if (got() !== e || bus.busW_Wr !== 32'h8000_00F1 || bus.RegWr_Wr !== 1'b1) begin
            errors++; $display("FAIL lw_after_sw got %h want %h", got(), e);
        end
        t = ld_t(32'h13, 2'b00, 5'd4); t.rw = 0;
        cycle(t, e);
        checks++;
        if (got() !== e || bus.busW_Wr !== 32'h8000_00F1 || bus.RegWr_Wr !== 1'b0) begin
            errors++; $display("FAIL lw_unaligned_norw got %h want %h", got(), e);
        end
    endtask

    task automatic test_sb_lb();
        logic [39:0] e;
        txn_t t;
        logic [31:0] want [4];
        logic [1:0]  lbs  [4];
        want[0] = 32'h11AA_3344; want[1] = 32'hFFFF_FFAA;
        want[2] = 32'h0000_00AA; want[3] = 32'h11AA_3344;
        lbs[0] = 2'b00; lbs[1] = 2'b01; lbs[2] = 2'b10; lbs[3] = 2'b11;
        cycle(sw_t(32'h10, 32'h1122_3344), e);
        t = sw_t(32'h12, 32'h5566_77AA); t.wb = 1;
        cycle(t, e);
        for (int i = 0; i < 4; i++) begin
            cycle(ld_t((i == 0 || i == 3) ? 32'h10 : 32'h12, lbs[i], 5'd9), e);
            checks++;
            if (got() !== e || bus.busW_Wr !== want[i]) begin
                errors++; $display("FAIL sb_load_%0d got %h want %h", i, bus.busW_Wr, want[i]);
            end
        end
    endtask

    task automatic test_branch();
        txn_t t;
        logic [39:0] e;
        t = nop(); t.br = 1; t.zf = 1; t.baddr = $urandom;
        apply(t); #1;
        checks++;
        if (bus.PC_Src_Mem !== 1'b1 || bus.B_Addr_out_Mem !== t.baddr) begin
            errors++; $display("FAIL branch_taken got %b/%h want 1/%h", bus.PC_Src_Mem, bus.B_Addr_out_Mem, t.baddr);
        end
        t.zf = 0; apply(t); #1;
        checks++;
        if (bus.PC_Src_Mem !== 1'b0) begin
            errors++; $display("FAIL branch_zf0 got %b want 0", bus.PC_Src_Mem);
        end
        t.zf = 1; t.flush = 1; apply(t); #1;
        checks++;
        if (bus.PC_Src_Mem !== 1'b0) begin
            errors++; $display("FAIL branch_flush got %b want 0", bus.PC_Src_Mem);
        end
        cycle(nop(), e);
    endtask

    task automatic test_jal();
        txn_t t;
        logic [39:0] e;
        t = ld_t(32'h10, 2'b00, 5'd31); t.jal = 1; t.pc = 32'h0000_0044;
        cycle(t, e);
        checks++;
        if (got() !== e || bus.busW_Wr !== 32'h44 || bus.Rw_Wr !== 5'd31 || bus.Jal_Wr !== 1'b1) begin
            errors++; $display("FAIL jal got %h want %h", got(), e);
        end
    endtask

    task automatic test_flush_alias();
        txn_t t;
        logic [39:0] e;
        cycle(sw_t(32'h20, 32'hCAFE_0001), e);
        t = sw_t(32'h20, 32'hBAD0_BAD0); t.flush = 1; t.rw = 1; t.rt = 5'd2; t.of = 1;
        cycle(t, e);
        checks++;
        if (got() !== 40'h0) begin
            errors++; $display("FAIL flush_bubble got %h want %h", got(), 40'h0);
        end
        cycle(ld_t(32'h20, 2'b00, 5'd2), e);
        checks++;
        if (got() !== e || bus.busW_Wr !== 32'hCAFE_0001) begin
            errors++; $display("FAIL flush_no_store got %h want %h", bus.busW_Wr, 32'hCAFE_0001);
        end
        cycle(sw_t(32'h1020, 32'h0A11_A5ED), e);
        cycle(ld_t(32'h20, 2'b00, 5'd2), e);
        checks++;
        if (got() !== e || bus.busW_Wr !== 32'h0A11_A5ED) begin
            errors++; $display("FAIL alias_word8 got %h want %h", bus.busW_Wr, 32'h0A11_A5ED);
        end
    endtask

    task automatic test_random();
        txn_t t;
        logic [39:0] e;
        int bad;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            t.flush = ($urandom_range(0, 7) == 0);
            t.alu   = (($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_F000) : 32'h0)
                      | 32'($urandom_range(0, 255));
            t.busb  = $urandom;  t.baddr = $urandom;  t.pc = $urandom;
            t.rt    = 5'($urandom);
            t.zf    = 1'($urandom); t.of = 1'($urandom); t.br = 1'($urandom);
            t.rw    = 1'($urandom); t.jal = ($urandom_range(0, 7) == 0);
            t.mw    = 1'($urandom); t.wb = 1'($urandom);
            t.m2r   = t.mw ? 1'b0 : 1'($urandom);
            t.lb    = 2'($urandom);
            apply(t); #1;
            checks++;
            if (bus.PC_Src_Mem !== (t.br & t.zf & ~t.flush) || bus.B_Addr_out_Mem !== t.baddr) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_branch_%0d got %b want %b", n, bus.PC_Src_Mem, t.br & t.zf & ~t.flush);
            end
            cycle(t, e);
            checks++;
            if (got() !== e) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_wr_%0d got %h want %h", n, got(), e);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sw_lw();
        test_sb_lb();
        test_branch();
        test_jal();
        test_flush_alias();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_206.md
Name: mem_stage_206

Overview:
- Memory-access stage of the 5-stage pipelined MIPS CPU. Consumes the Ex/Mem pipeline register outputs.
- Contains the data memory, with word and byte stores and signed/unsigned byte loads.
- Resolves branch-taken for the fetch unit's PC_Src input.
- Contains the Mem/Wr pipeline register that drives the ID unit's write-back inputs (busW, Rw_Wr, RegWr_Wr, OverFlow_Wr, Jal_Wr).

Parameters:
- DEPTH, 1024, number of 32-bit data-memory words (power of two).
- ADDR_W, 10, log2(DEPTH); word-index width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush_Mem  in  1  turns the instruction in Mem into a bubble (no store, no write-back).
- ALU_ans_Mem  in  32  ALU result; this is the memory byte address for loads and stores.
- busB_Mem  in  32  store data.
- B_Addr_Mem  in  32  branch target.
- PC_Addr_Mem  in  32  PC+4 of this instruction, used as the jal link value.
- Reg_Target_Mem  in  5  destination register.
- ZF_Mem  in  1  ALU zero flag.
- OF_Mem  in  1  ALU overflow flag.
- Branch_Mem  in  1  instruction is a branch.
- MemToReg_Mem  in  1  write-back source is memory.
- RegWr_Mem  in  1  instruction writes a register.
- MemWr_Mem  in  1  instruction is a store.
- Jal_Mem  in  1  instruction is jal.
- WrByte_Mem  in  1  store is sb (byte) rather than sw.
- LoadByte_Mem  in  2  load type: 00 lw, 01 lb, 10 lbu, 11 treated as lw.
- PC_Src_Mem  out  1  branch taken (combinational).
- B_Addr_out_Mem  out  32  branch target to the fetch unit.
- busW_Wr  out  32  registered write-back data.
- Rw_Wr  out  5  registered destination register.
- RegWr_Wr  out  1  registered register-write enable.
- OverFlow_Wr  out  1  registered overflow flag.
- Jal_Wr  out  1  registered jal flag.

Behaviour:
- Reset (async, rst=1):
  - All Wr outputs go to 0 immediately: busW_Wr=0, Rw_Wr=0, RegWr_Wr=0, OverFlow_Wr=0, Jal_Wr=0.
  - Data memory contents are not reset; the simulation model initialises them to 0.
  - While rst is high, stores are inhibited.
- Addressing:
  - Word index = ALU_ans_Mem[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = ALU_ans_Mem[1:0], little-endian: lane 0 is bits [7:0].
  - sw with nonzero low address bits writes the aligned word; low bits are ignored, no trap.
- Store (synchronous, rising edge):
  - Active when MemWr_Mem & ~flush_Mem & ~rst.
  - WrByte_Mem=0: write the full word busB_Mem.
  - WrByte_Mem=1: write busB_Mem[7:0] into the selected lane only; the other 3 bytes are unchanged.
- Load read:
  - Combinational read of the addressed word.
  - lw: the full word.
  - lb: selected byte, sign-extended to 32 bits.
  - lbu: selected byte, zero-extended to 32 bits.
- Write-back mux, evaluated in Mem and captured at the edge, priority order:
  1. Jal_Mem: busW = PC_Addr_Mem.
  2. Else MemToReg_Mem: busW = load data.
  3. Else: busW = ALU_ans_Mem.
- Latency:
  - One cycle from Mem inputs to Wr outputs.
  - A store at edge N is visible to a load presented in cycle N+1.
  - A store and a load cannot occur in the same instruction, so there is no same-cycle hazard.
- Flush:
  - flush_Mem=1 at an edge captures a bubble: RegWr_Wr=0, Jal_Wr=0, OverFlow_Wr=0, Rw_Wr=0, busW_Wr=0.
  - The store is suppressed.
  - PC_Src_Mem is forced to 0.
- Branch:
  - PC_Src_Mem = Branch_Mem & ZF_Mem & ~flush_Mem.
  - B_Addr_out_Mem = B_Addr_Mem.
- OverFlow_Wr carries OF_Mem unchanged; the ID unit uses it to suppress the register write. This block does not alter RegWr for overflow.
- No stall input: the Mem/Wr register loads every cycle.
- Reset deasserting mid-pipeline: the first edge after deassertion captures the current inputs normally.

Decomposition:
- Shared package:
  - LoadByte encodings: LB_WORD=2'b00, LB_SIGNED=2'b01, LB_UNSIGNED=2'b10.
  - Default DEPTH and ADDR_W.
- One sub-module: data_mem_206.
  - Contents: word array, byte-lane write enable, combinational read.
  - The stage top holds the load extension, the write-back mux, branch resolution and the Mem/Wr register.

Test Plan:
- Reset while Wr outputs are nonzero -> all Wr outputs 0 without waiting for a clock edge; no store occurs while rst=1.
- sw 0x8000_00F1 to addr 0x10, then lw from 0x10 the next cycle -> busW_Wr=0x8000_00F1 one cycle later; RegWr_Wr follows RegWr_Mem.
- Word 0x10 = 0x1122_3344; sb 0xAA to addr 0x12 -> word becomes 0x11AA_3344; lb from 0x12 -> 0xFFFF_FFAA; lbu from 0x12 -> 0x0000_00AA.
- Branch_Mem=1 with ZF_Mem=1 -> PC_Src_Mem=1 and B_Addr_out_Mem=B_Addr_Mem; same stimulus with ZF_Mem=0 or flush_Mem=1 -> PC_Src_Mem=0.
- Jal_Mem=1, PC_Addr_Mem=0x0000_0044, Reg_Target_Mem=31 -> busW_Wr=0x44, Rw_Wr=31, Jal_Wr=1; Jal takes priority even when MemToReg_Mem=1.
- flush_Mem=1 during sw to addr 0x20 -> memory at 0x20 unchanged, RegWr_Wr=0; address 0x1000+0x20 with DEPTH=1024 -> aliases word 8.
